// File: rtl/qft3_stream_ctrl.sv
// Streaming valid/ready front end for the fixed-latency 3-qubit QFT datapath.
// Credit-based admission sizes in-flight work to the result FIFO so the datapath never needs to stall.
`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH 6
`endif

module qft3_stream_ctrl #(
  parameter int W          = `TOTAL_WIDTH,
  parameter int LATENCY    = 19,
  parameter int FIFO_DEPTH = 24,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [16*W-1:0]   s_data,
  output logic [16*W-1:0]   pipe_in,
  input  logic [16*W-1:0]   pipe_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [16*W-1:0]   m_data,
  input  logic              flush,
  output logic              busy,
  output logic              ovf_err,
  output logic [CNT_W-1:0]  acc_cnt,
  output logic [CNT_W-1:0]  dlv_cnt
);

  localparam int DW    = 16 * W;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [OCC_W-1:0] DEPTH_V  = OCC_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  logic [OCC_W-1:0]   credits;
  logic [OCC_W-1:0]   fifo_cnt;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [DW-1:0]      fifo_mem [FIFO_DEPTH];
  logic               in_valid;
  logic [LATENCY-1:0] tokens;
  logic               accept;
  logic               pop;
  logic               push;
  logic               fifo_full;
  logic               fifo_empty;
  logic               wr_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign s_ready    = (credits != '0) & ~flush;
  assign accept     = s_valid & s_ready;
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == DEPTH_V);
  assign m_valid    = ~fifo_empty;
  assign pop        = m_valid & m_ready;
  assign push       = tokens[LATENCY-1];
  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
  assign wr_en      = push & (~fifo_full | pop);
  assign m_data     = fifo_mem[rd_ptr];
  assign busy       = in_valid | (|tokens) | ~fifo_empty;

  // in_valid marks the cycle pipe_in carries a vector; tokens then track it through the datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_valid <= 1'b0;
      pipe_in  <= '0;
      tokens   <= '0;
    end else if (flush) begin
      in_valid <= 1'b0;
      pipe_in  <= '0;
      tokens   <= '0;
    end else begin
      in_valid <= accept;
      pipe_in  <= accept ? s_data : '0;
      tokens   <= {tokens[LATENCY-2:0], in_valid};
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) fifo_mem[wr_ptr] <= pipe_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      credits  <= DEPTH_V;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      credits  <= DEPTH_V;
    end else begin
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)   rd_ptr <= ptr_inc(rd_ptr);
      fifo_cnt <= fifo_cnt + OCC_W'(wr_en) - OCC_W'(pop);
      credits  <= credits - OCC_W'(accept) + OCC_W'(pop);
    end
  end

  // Counters and the overflow flag survive flush; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_err <= 1'b0;
      acc_cnt <= '0;
      dlv_cnt <= '0;
    end else begin
      if (push & fifo_full & ~pop) ovf_err <= 1'b1;
      acc_cnt <= acc_cnt + CNT_W'(accept);
      dlv_cnt <= dlv_cnt + CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_qft3_stream_ctrl.sv
// Directed bench for qft3_stream_ctrl; a delay-line stand-in plays the QFT datapath.
module tb_qft3_stream_ctrl;

  localparam int W     = 6;
  localparam int LAT   = 19;
  localparam int DEPTH = 24;
  localparam int CNT_W = 16;
  localparam int DW    = 16 * W;
  localparam int TW_R [8] = '{5, 4, 0, -4, -5, -4, 0, 4};
  localparam int TW_I [8] = '{0, 4, 5, 4, 0, -4, -5, -4};

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [DW-1:0]    s_data = '0;
  logic [DW-1:0]    pipe_in;
  logic [DW-1:0]    pipe_out;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [DW-1:0]    m_data;
  logic             flush = 1'b0;
  logic             busy;
  logic             ovf_err;
  logic [CNT_W-1:0] acc_cnt;
  logic [CNT_W-1:0] dlv_cnt;

  qft3_stream_ctrl #(.W(W), .LATENCY(LAT), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .pipe_in(pipe_in), .pipe_out(pipe_out), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .flush(flush), .busy(busy), .ovf_err(ovf_err),
    .acc_cnt(acc_cnt), .dlv_cnt(dlv_cnt)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Basis input (single real 16 at amplitude j) -> exact QFT column; anything else passes through.
  function automatic logic [DW-1:0] dp_model(input logic [DW-1:0] x);
    logic [DW-1:0] y;
    int nz, j, m;
    nz = 0;
    j  = 0;
    y  = x;
    for (int k = 0; k < 16; k++)
      if (x[k*W +: W] != '0) begin
        nz++;
        j = k;
      end
    if (nz == 1 && (j % 2) == 0 && x[j*W +: W] == W'(16)) begin
      for (int k = 0; k < 8; k++) begin
        m = ((j / 2) * k) % 8;
        y[(2*k)*W +: W]   = W'(TW_R[m]);
        y[(2*k+1)*W +: W] = W'(TW_I[m]);
      end
    end
    return y;
  endfunction

  function automatic logic [DW-1:0] mkvec(input int id);
    logic [DW-1:0] v;
    for (int k = 0; k < 16; k++) v[k*W +: W] = W'(id + 5 * k + 1);
    return v;
  endfunction

  logic [LAT*DW-1:0] dly = '0;
  always @(posedge clk) dly <= {dly[(LAT-1)*DW-1:0], pipe_in};
  assign pipe_out = dp_model(dly[LAT*DW-1 -: DW]);

  // Scoreboard: every accept queues its expected result, every pop must match the head.
  logic [DW-1:0] exp_q[$];
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid && m_ready) begin
        $display("  pop  t=%0t data=%h", $time, m_data);
        check("pop_has_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) check("pop_data", m_data, exp_q.pop_front());
      end
      if (s_valid && s_ready) begin
        $display("  acc  t=%0t data=%h", $time, s_data);
        exp_q.push_back(dp_model(s_data));
      end
      if (flush) exp_q.delete();
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next();
    rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  logic [DW-1:0] vec;
  logic [DW-1:0] exp2;
  int e2 [16] = '{5, 0, 0, -5, -5, 0, 0, 5, 5, 0, 0, -5, -5, 0, 0, 5};
  int lat, bad, nacc, id;
  logic took;

  initial begin
    // 1. reset
    do_reset();
    @(negedge clk);
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_acc_cnt", acc_cnt, 0);
    check("rst_dlv_cnt", dlv_cnt, 0);
    check("rst_ovf_err", ovf_err, 1'b0);

    // 2. single basis vector |110>
    next();
    vec = '0;
    vec[12*W +: W] = W'(16);
    for (int k = 0; k < 16; k++) exp2[k*W +: W] = W'(e2[k]);
    m_ready = 1'b1; s_valid = 1'b1; s_data = vec;
    @(negedge clk);
    check("t2_accept", s_ready, 1'b1);
    lat = -1;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      next();
      s_valid = 1'b0; s_data = '0;
      @(negedge clk);
      if (n == 1) check("t2_pipe_in", pipe_in, vec);
      if (n == 2) check("t2_pipe_in_idle", pipe_in, '0);
      if (m_valid) begin
        lat = n;
        check("t2_m_data", m_data, exp2);
      end
    end
    check("t2_latency", lat, 21);
    next();
    @(negedge clk);
    check("t2_dlv_cnt", dlv_cnt, 1);
    check("t2_m_valid_low", m_valid, 1'b0);

    // 3. full throughput
    do_reset();
    m_ready = 1'b1;
    bad = 0;
    for (int n = 0; n < 66; n++) begin
      if (n > 0) next();
      s_valid = (n < 40);
      s_data  = mkvec(n);
      @(negedge clk);
      if (n < 40 && !s_ready) bad++;
      if (m_valid != (n >= 21 && n <= 60)) bad++;
    end
    check("t3_stream_shape", bad, 0);
    check("t3_acc_cnt", acc_cnt, 40);
    check("t3_dlv_cnt", dlv_cnt, 40);
    check("t3_all_delivered", exp_q.size(), 0);

    // 4. backpressure: credits run out at FIFO_DEPTH
    do_reset();
    m_ready = 1'b0; s_valid = 1'b1; id = 100; s_data = mkvec(id);
    nacc = 0; took = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (n > 0) begin
        next();
        if (took) begin id++; s_data = mkvec(id); end
      end
      @(negedge clk);
      took = s_valid & s_ready;
      if (took) nacc++;
    end
    check("t4_accepted", nacc, 24);
    check("t4_acc_cnt", acc_cnt, 24);
    check("t4_s_ready_low", s_ready, 1'b0);
    check("t4_m_valid", m_valid, 1'b1);
    next();
    m_ready = 1'b1;
    @(negedge clk);
    check("t4_ready_in_pop_cycle", s_ready, 1'b0);
    next();
    @(negedge clk);
    check("t4_ready_after_pop", s_ready, 1'b1);
    next();
    s_valid = 1'b0;
    repeat (60) next();
    @(negedge clk);
    check("t4_dlv_cnt", dlv_cnt, 25);
    check("t4_ovf_err", ovf_err, 1'b0);
    check("t4_all_delivered", exp_q.size(), 0);

    // 5. flush with results in flight
    do_reset();
    m_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      if (n > 0) next();
      s_valid = 1'b1; s_data = mkvec(200 + n);
      @(negedge clk);
    end
    next();
    s_valid = 1'b0;
    repeat (9) next();
    flush = 1'b1;
    @(negedge clk);
    check("t5_ready_in_flush", s_ready, 1'b0);
    next();
    flush = 1'b0;
    @(negedge clk);
    check("t5_busy_after", busy, 1'b0);
    check("t5_m_valid_after", m_valid, 1'b0);
    bad = 0;
    for (int n = 0; n < 30; n++) begin
      next();
      @(negedge clk);
      if (m_valid) bad++;
    end
    check("t5_no_stale_results", bad, 0);
    check("t5_acc_cnt", acc_cnt, 3);
    check("t5_dlv_cnt", dlv_cnt, 0);
    next();
    s_valid = 1'b1; s_data = mkvec(250);
    @(negedge clk);
    check("t5_accept_after", s_ready, 1'b1);
    lat = -1;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      next();
      s_valid = 1'b0;
      @(negedge clk);
      if (m_valid) begin
        lat = n;
        check("t5_m_data", m_data, mkvec(250));
      end
    end
    check("t5_latency", lat, 21);
    // credits back to full after the flush
    next();
    m_ready = 1'b0; s_valid = 1'b1; nacc = 0;
    for (int n = 0; n < 30; n++) begin
      if (n > 0) next();
      @(negedge clk);
      if (s_valid && s_ready) nacc++;
    end
    check("t5_credits", nacc, 24);

    // 6. asynchronous reset between edges, mid-stream
    @(posedge clk);
    #3;
    check("t6_pre_m_valid", m_valid, 1'b1);
    check("t6_pre_s_ready", s_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t6_m_valid", m_valid, 1'b0);
    check("t6_busy", busy, 1'b0);
    check("t6_s_ready", s_ready, 1'b1);
    check("t6_acc_cnt", acc_cnt, 0);
    check("t6_dlv_cnt", dlv_cnt, 0);
    s_valid = 1'b0;
    next();
    rst_n = 1'b1;
    exp_q.delete();
    repeat (2) next();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
